flow_ctrl: RTL
==============

Name: flow_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It produces the per-stage flow codes (WORK/STOP/REFRESH) for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC hold. It resolves load-use hazards, taken branch/jump flushes, traps, data-bus wait states and multi-cycle mul/div stalls. It holds a small FSM for mul/div waits, a mul/div watchdog, and a stall-cycle performance counter.

Parameters:
FLOW_WIDTH, 2, width of flow code
FLOW_WORK, 2'b00, pipeline register loads its inputs
FLOW_STOP, 2'b01, pipeline register holds its value
FLOW_REFRESH, 2'b10, pipeline register loads its bubble/reset value
REG_ADDR_WIDTH, 5, register address width
MD_MAX_CYCLES, 64, mul/div watchdog limit in cycles
CNT_WIDTH, 32, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ex_load_i  in  1  instruction in EX is a load
ex_rd_i  in  REG_ADDR_WIDTH  destination register of the EX instruction
id_rs1_i  in  REG_ADDR_WIDTH  rs1 of the ID instruction
id_rs2_i  in  REG_ADDR_WIDTH  rs2 of the ID instruction
id_rs1_used_i  in  1  ID instruction reads rs1
id_rs2_used_i  in  1  ID instruction reads rs2
jump_taken_i  in  1  EX resolved a taken branch or jump
trap_i  in  1  interrupt/exception redirect this cycle
mem_req_i  in  1  data-bus request outstanding
mem_ack_i  in  1  data-bus acknowledge
md_start_i  in  1  EX issues a mul/div (single-cycle pulse)
md_done_i  in  1  mul/div result valid
md_kill_o  out  1  abort the mul/div unit
md_timeout_o  out  1  watchdog expiry pulse
pc_hold_o  out  1  PC holds its value
flow_if_id_o  out  FLOW_WIDTH  IF/ID flow code
flow_id_ex_o  out  FLOW_WIDTH  ID/EX flow code
flow_ex_mem_o  out  FLOW_WIDTH  EX/MEM flow code
flow_mem_wb_o  out  FLOW_WIDTH  MEM/WB flow code
stall_cnt_o  out  CNT_WIDTH  count of cycles with pc_hold_o=1

Behaviour:
- Reset is asynchronous, active-low on rst_n; the clock is clk.
- While rst_n=0:
  - state=S_RUN, watchdog=0, stall_cnt_o=0.
  - All flow outputs are forced to FLOW_WORK.
  - pc_hold_o, md_kill_o and md_timeout_o are 0.
- The flow, pc_hold and md_kill outputs are combinational from state and inputs, so they take effect at the same clock edge.
- Default when no condition below applies: all four flows WORK, pc_hold_o=0.
- Conditions are evaluated in strict priority order; the first match wins:
  1. Mem wait (mem_req_i & ~mem_ack_i):
     - All four flows STOP, pc_hold_o=1.
     - FSM state and watchdog are frozen.
     - A trap or jump presented in the same cycle is ignored; its source holds it until the wait clears.
  2. Trap (trap_i):
     - IF/ID, ID/EX and EX/MEM REFRESH; MEM/WB WORK; pc_hold_o=0.
     - In S_MD_WAIT, or in the md_start_i cycle: md_kill_o=1, next state S_RUN, watchdog cleared.
  3. Mul/div stall, i.e. S_MD_WAIT & ~md_done_i, or S_RUN & md_start_i & ~md_done_i:
     - pc_hold_o=1; IF/ID and ID/EX STOP; EX/MEM REFRESH (bubble); MEM/WB WORK.
  4. Jump (jump_taken_i):
     - IF/ID and ID/EX REFRESH; EX/MEM and MEM/WB WORK; pc_hold_o=0.
     - Jump wins over a load-use hazard in the same cycle.
  5. Load-use: ex_load_i & ex_rd_i!=0 & ((id_rs1_used_i & id_rs1_i==ex_rd_i) | (id_rs2_used_i & id_rs2_i==ex_rd_i)):
     - pc_hold_o=1; IF/ID STOP; ID/EX REFRESH; others WORK.
     - Exactly one bubble, because the load moves to MEM the next cycle.
- FSM transitions:
  - S_RUN → S_MD_WAIT on md_start_i & ~md_done_i & ~trap_i, when no mem wait is active.
  - md_start_i & md_done_i in the same cycle: no stall, stay in S_RUN.
  - S_MD_WAIT → S_RUN on md_done_i. The done cycle produces the default flows, so the result is captured into EX/MEM.
  - S_MD_WAIT → S_RUN on trap_i.
  - S_MD_WAIT → S_RUN on watchdog expiry.
  - md_start_i is ignored while in S_MD_WAIT.
- Watchdog:
  - Counts cycles spent in S_MD_WAIT; cleared on entry and on exit.
  - When the count reaches MD_MAX_CYCLES-1 without md_done_i: md_timeout_o=1 and md_kill_o=1 for one cycle; next state S_RUN.
  - The expiry cycle itself is still a stall cycle.
- stall_cnt_o: increments by 1 on every clock edge where pc_hold_o=1; saturates at all-ones and never wraps.

Test Plan:
- Load-use: ex_load_i=1, ex_rd_i=5, id_rs2_i=5, id_rs2_used_i=1 for one cycle → pc_hold_o=1, IF/ID=STOP, ID/EX=REFRESH, EX/MEM=MEM/WB=WORK; next cycle all WORK; stall_cnt_o=1. Repeat with ex_rd_i=0 → no stall.
- Jump with simultaneous load-use → IF/ID=ID/EX=REFRESH, pc_hold_o=0, stall_cnt_o unchanged.
- Mul/div: md_start_i pulse, md_done_i 10 cycles later → 10 stall cycles with EX/MEM=REFRESH; default flows on the done cycle; state back to S_RUN; stall_cnt_o=10. Also: start and done in the same cycle → no stall.
- Watchdog: MD_MAX_CYCLES=8, md_start_i, md_done_i never asserted → md_timeout_o and md_kill_o pulse on the 8th stall cycle; back in S_RUN; no stall on the following cycle.
- Mem wait during S_MD_WAIT with trap_i asserted: mem_req_i=1, mem_ack_i=0 for 3 cycles → all flows STOP and the watchdog is frozen. On the ack cycle with trap_i still high → IF/ID, ID/EX, EX/MEM REFRESH, md_kill_o=1, S_RUN.
- Reset asserted mid-S_MD_WAIT → all outputs WORK/0 immediately; stall_cnt_o=0; after release, no stall until a new md_start_i.

Source files
------------

// File: rtl/flow_ctrl.sv
// Pipeline flow sequencer for the 5-stage core: per-stage WORK/STOP/REFRESH codes,
// PC hold, mul/div wait FSM with watchdog, and a saturating stall-cycle counter.
module flow_ctrl #(
    parameter int                    FLOW_WIDTH     = 2,
    parameter logic [FLOW_WIDTH-1:0] FLOW_WORK      = 2'b00,
    parameter logic [FLOW_WIDTH-1:0] FLOW_STOP      = 2'b01,
    parameter logic [FLOW_WIDTH-1:0] FLOW_REFRESH   = 2'b10,
    parameter int                    REG_ADDR_WIDTH = 5,
    parameter int                    MD_MAX_CYCLES  = 64,
    parameter int                    CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_load_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
    input  logic                      id_rs1_used_i,
    input  logic                      id_rs2_used_i,
    input  logic                      jump_taken_i,
    input  logic                      trap_i,
    input  logic                      mem_req_i,
    input  logic                      mem_ack_i,
    input  logic                      md_start_i,
    input  logic                      md_done_i,
    output logic                      md_kill_o,
    output logic                      md_timeout_o,
    output logic                      pc_hold_o,
    output logic [FLOW_WIDTH-1:0]     flow_if_id_o,
    output logic [FLOW_WIDTH-1:0]     flow_id_ex_o,
    output logic [FLOW_WIDTH-1:0]     flow_ex_mem_o,
    output logic [FLOW_WIDTH-1:0]     flow_mem_wb_o,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

    localparam int WD_W = (MD_MAX_CYCLES > 2) ? $clog2(MD_MAX_CYCLES) : 1;

    typedef enum logic [0:0] {
        S_RUN     = 1'b0,
        S_MD_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [WD_W-1:0]     r_wdCnt;
    logic [WD_W-1:0]     w_wdNext;
    logic [CNT_WIDTH-1:0] r_stallCnt;

    logic w_memWait;
    logic w_inWait;
    logic w_mdStall;
    logic w_loadUse;
    logic w_wdExpire;
    logic w_rs1Hit;
    logic w_rs2Hit;

    assign w_memWait = mem_req_i & ~mem_ack_i;
    assign w_inWait  = (r_state == S_MD_WAIT);
    assign w_mdStall = (w_inWait & ~md_done_i) | (~w_inWait & md_start_i & ~md_done_i);

    assign w_rs1Hit  = id_rs1_used_i & (id_rs1_i == ex_rd_i);
    assign w_rs2Hit  = id_rs2_used_i & (id_rs2_i == ex_rd_i);
    assign w_loadUse = ex_load_i & (ex_rd_i != '0) & (w_rs1Hit | w_rs2Hit);

    // The issue cycle is the first stall cycle, so expiry lands on stall cycle MD_MAX_CYCLES.
    assign w_wdExpire = w_inWait & ~md_done_i & ~w_memWait & ~trap_i &
                        (r_wdCnt == WD_W'(MD_MAX_CYCLES - 2));

    always_comb begin
        flow_if_id_o  = FLOW_WORK;
        flow_id_ex_o  = FLOW_WORK;
        flow_ex_mem_o = FLOW_WORK;
        flow_mem_wb_o = FLOW_WORK;
        pc_hold_o     = 1'b0;
        md_kill_o     = 1'b0;
        md_timeout_o  = 1'b0;
        if (rst_n) begin
            if (w_memWait) begin
                flow_if_id_o  = FLOW_STOP;
                flow_id_ex_o  = FLOW_STOP;
                flow_ex_mem_o = FLOW_STOP;
                flow_mem_wb_o = FLOW_STOP;
                pc_hold_o     = 1'b1;
            end else if (trap_i) begin
                flow_if_id_o  = FLOW_REFRESH;
                flow_id_ex_o  = FLOW_REFRESH;
                flow_ex_mem_o = FLOW_REFRESH;
                md_kill_o     = w_inWait | md_start_i;
            end else if (w_mdStall) begin
                flow_if_id_o  = FLOW_STOP;
                flow_id_ex_o  = FLOW_STOP;
                flow_ex_mem_o = FLOW_REFRESH;
                pc_hold_o     = 1'b1;
                md_kill_o     = w_wdExpire;
                md_timeout_o  = w_wdExpire;
            end else if (jump_taken_i) begin
                flow_if_id_o  = FLOW_REFRESH;
                flow_id_ex_o  = FLOW_REFRESH;
            end else if (w_loadUse) begin
                flow_if_id_o  = FLOW_STOP;
                flow_id_ex_o  = FLOW_REFRESH;
                pc_hold_o     = 1'b1;
            end
        end
    end

    // Mul/div wait FSM; a data-bus wait freezes both the state and the watchdog.
    always_comb begin
        w_stateNext = r_state;
        w_wdNext    = r_wdCnt;
        if (!w_memWait) begin
            case (r_state)
                S_RUN: begin
                    if (md_start_i & ~md_done_i & ~trap_i) begin
                        w_stateNext = S_MD_WAIT;
                        w_wdNext    = '0;
                    end
                end
                S_MD_WAIT: begin
                    if (trap_i | md_done_i | w_wdExpire) begin
                        w_stateNext = S_RUN;
                        w_wdNext    = '0;
                    end else begin
                        w_wdNext = r_wdCnt + WD_W'(1);
                    end
                end
                default: begin
                    w_stateNext = S_RUN;
                    w_wdNext    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_wdCnt <= '0;
        end else begin
            r_state <= w_stateNext;
            r_wdCnt <= w_wdNext;
        end
    end

    // Saturating count of PC-hold cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
        end else if (pc_hold_o && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + CNT_WIDTH'(1);
        end
    end

    assign stall_cnt_o = r_stallCnt;

endmodule
